// File: rtl/armleocpu_fetch_queue.sv
// Instruction fetch unit: issues EXECUTE/FLUSH_ALL to the I-cache, keeps one request
// outstanding and buffers returned words in a DEPTH-entry FIFO for decode.
module armleocpu_fetch_queue #(
  parameter logic [31:0] RESET_VECTOR            = 32'h0000_2000,
  parameter int          DEPTH                   = 4,
  parameter int          F2E_TYPE_WIDTH          = 2,
  parameter int          ARMLEOCPU_E2F_CMD_WIDTH = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic [3:0]                         c_cmd,
  output logic [31:0]                        c_address,
  input  logic                               c_done,
  input  logic [3:0]                         c_response,
  input  logic [31:0]                        c_load_data,
  input  logic                               interrupt_pending,
  input  logic                               dbg_mode,
  output logic                               busy,
  output logic                               f2d_valid,
  input  logic                               f2d_ready,
  output logic [F2E_TYPE_WIDTH-1:0]          f2d_type,
  output logic [31:0]                        f2d_instr,
  output logic [31:0]                        f2d_pc,
  output logic [3:0]                         f2d_resp,
  input  logic                               e2f_ready,
  input  logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] e2f_cmd,
  input  logic [31:0]                        e2f_branchtarget
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
  localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] E2F_CMD_ABORT        = ARMLEOCPU_E2F_CMD_WIDTH'(1);
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] E2F_CMD_START_BRANCH = ARMLEOCPU_E2F_CMD_WIDTH'(2);
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] E2F_CMD_FLUSH        = ARMLEOCPU_E2F_CMD_WIDTH'(3);

  localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INSTR             = F2E_TYPE_WIDTH'(0);
  localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INTERRUPT_PENDING = F2E_TYPE_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FLUSH} state_t;

  state_t             state, state_nxt;
  logic [3:0]         c_cmd_nxt;
  logic [31:0]        c_address_nxt;
  logic [31:0]        fetch_pc, fetch_pc_nxt, seq_pc;
  logic               stale, stale_nxt;
  logic               flush_pending, flush_pending_nxt;
  logic               redirect_pending, redirect_pending_nxt;
  logic [31:0]        redirect_target, redirect_target_nxt;

  logic [31:0]        fifo_pc    [DEPTH];
  logic [31:0]        fifo_instr [DEPTH];
  logic [3:0]         fifo_resp  [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count, occupancy;

  logic e2f_abort, e2f_branch, e2f_flush, redirect_now;
  logic fetch_done, push, pop, can_issue;

  assign e2f_abort    = e2f_ready && (e2f_cmd == E2F_CMD_ABORT);
  assign e2f_branch   = e2f_ready && (e2f_cmd == E2F_CMD_START_BRANCH);
  assign e2f_flush    = e2f_ready && (e2f_cmd == E2F_CMD_FLUSH);
  assign redirect_now = e2f_branch || e2f_flush;

  // A redirect empties the FIFO on this edge, so it overrides both push and pop.
  assign fetch_done = (state == ST_FETCH) && c_done;
  assign push       = fetch_done && !stale && !redirect_now;
  assign pop        = (count != '0) && f2d_ready && !interrupt_pending && !redirect_now;
  assign occupancy  = redirect_now ? '0 : count + CNT_W'(push);
  assign can_issue  = ((state == ST_IDLE) || c_done) && !dbg_mode && !e2f_abort
                      && (occupancy < CNT_W'(DEPTH));
  assign seq_pc     = fetch_done ? fetch_pc + 32'd4 : fetch_pc;

  always_comb begin
    state_nxt            = state;
    c_cmd_nxt            = c_cmd;
    c_address_nxt        = c_address;
    fetch_pc_nxt         = seq_pc;
    stale_nxt            = stale;
    flush_pending_nxt    = flush_pending;
    redirect_pending_nxt = redirect_pending;
    redirect_target_nxt  = redirect_target;

    if (fetch_done && stale)
      stale_nxt = 1'b0;
    if (redirect_now) begin
      redirect_pending_nxt = 1'b1;
      redirect_target_nxt  = e2f_branchtarget;
      if ((state == ST_FETCH) && !c_done)
        stale_nxt = 1'b1;
    end
    if (e2f_flush)
      flush_pending_nxt = 1'b1;

    if (can_issue) begin
      if (flush_pending || e2f_flush) begin
        state_nxt         = ST_FLUSH;
        c_cmd_nxt         = CACHE_CMD_FLUSH_ALL;
        c_address_nxt     = redirect_target_nxt;
        flush_pending_nxt = 1'b0;
      end else begin
        state_nxt = ST_FETCH;
        c_cmd_nxt = CACHE_CMD_EXECUTE;
        if (redirect_pending || e2f_branch) begin
          c_address_nxt        = redirect_target_nxt;
          fetch_pc_nxt         = redirect_target_nxt;
          redirect_pending_nxt = 1'b0;
        end else begin
          c_address_nxt = seq_pc;
        end
      end
    end else if (c_done && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      c_cmd_nxt = CACHE_CMD_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      c_cmd            <= CACHE_CMD_NONE;
      c_address        <= '0;
      fetch_pc         <= RESET_VECTOR;
      stale            <= 1'b0;
      flush_pending    <= 1'b0;
      redirect_pending <= 1'b1;
      redirect_target  <= RESET_VECTOR;
      count            <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
    end else begin
      state            <= state_nxt;
      c_cmd            <= c_cmd_nxt;
      c_address        <= c_address_nxt;
      fetch_pc         <= fetch_pc_nxt;
      stale            <= stale_nxt;
      flush_pending    <= flush_pending_nxt;
      redirect_pending <= redirect_pending_nxt;
      redirect_target  <= redirect_target_nxt;
      if (redirect_now) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)
          count <= count + CNT_W'(1);
        else if (pop && !push)
          count <= count - CNT_W'(1);
      end
    end
  end

  // FIFO payload carries no reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= fetch_pc;
      fifo_instr[wr_ptr] <= c_load_data;
      fifo_resp[wr_ptr]  <= c_response;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign f2d_valid = interrupt_pending || (count != '0);
  assign f2d_type  = interrupt_pending ? F2E_TYPE_INTERRUPT_PENDING : F2E_TYPE_INSTR;
  assign f2d_pc    = (count != '0) ? fifo_pc[rd_ptr] : fetch_pc;
  assign f2d_instr = fifo_instr[rd_ptr];
  assign f2d_resp  = fifo_resp[rd_ptr];

endmodule

// File: tb/tb_armleocpu_fetch_queue.sv
// Directed bench for armleocpu_fetch_queue: cycle vectors with hand-computed expectations
// plus a latency-3 cache run checking sequential delivery.
module tb_armleocpu_fetch_queue;

  localparam logic [3:0] NO = 4'd0, EX = 4'd1, FA = 4'd4;
  localparam logic [1:0] EN = 2'd0, AB = 2'd1, BR = 2'd2, FL = 2'd3;
  localparam logic [1:0] TI = 2'd0, TP = 2'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic        c_done = 1'b0;
  logic [3:0]  c_response = 4'd0;
  logic [31:0] c_load_data = 32'd0;
  logic        interrupt_pending = 1'b0;
  logic        dbg_mode = 1'b0;
  logic        busy;
  logic        f2d_valid;
  logic        f2d_ready = 1'b0;
  logic [1:0]  f2d_type;
  logic [31:0] f2d_instr;
  logic [31:0] f2d_pc;
  logic [3:0]  f2d_resp;
  logic        e2f_ready = 1'b0;
  logic [1:0]  e2f_cmd = 2'd0;
  logic [31:0] e2f_branchtarget = 32'd0;

  armleocpu_fetch_queue dut (
    .clk(clk), .rst_n(rst_n),
    .c_cmd(c_cmd), .c_address(c_address), .c_done(c_done),
    .c_response(c_response), .c_load_data(c_load_data),
    .interrupt_pending(interrupt_pending), .dbg_mode(dbg_mode), .busy(busy),
    .f2d_valid(f2d_valid), .f2d_ready(f2d_ready), .f2d_type(f2d_type),
    .f2d_instr(f2d_instr), .f2d_pc(f2d_pc), .f2d_resp(f2d_resp),
    .e2f_ready(e2f_ready), .e2f_cmd(e2f_cmd), .e2f_branchtarget(e2f_branchtarget)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          done;
    logic [3:0]  resp;
    bit          ready;
    logic [1:0]  e2f;
    logic [31:0] tgt;
    bit          irq;
    bit          dbg;
    logic [3:0]  ecmd;
    logic [31:0] eaddr;
    bit          ebusy;
    bit          evalid;
    logic [1:0]  etype;
    logic [31:0] epc;
    logic [3:0]  eresp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;
  int   row = 0;

  task automatic add(input bit rst, input bit done, input logic [3:0] resp, input bit ready,
                     input logic [1:0] e2f, input logic [31:0] tgt, input bit irq, input bit dbg,
                     input logic [3:0] ecmd, input logic [31:0] eaddr, input bit ebusy,
                     input bit evalid, input logic [1:0] etype, input logic [31:0] epc,
                     input logic [3:0] eresp);
    vec_t v;
    v.rst = rst; v.done = done; v.resp = resp; v.ready = ready; v.e2f = e2f; v.tgt = tgt;
    v.irq = irq; v.dbg = dbg; v.ecmd = ecmd; v.eaddr = eaddr; v.ebusy = ebusy;
    v.evalid = evalid; v.etype = etype; v.epc = epc; v.eresp = eresp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  task automatic zero_inputs();
    c_done = 1'b0; c_response = 4'd0; c_load_data = 32'd0; f2d_ready = 1'b0;
    e2f_ready = 1'b0; e2f_cmd = EN; e2f_branchtarget = 32'd0;
    interrupt_pending = 1'b0; dbg_mode = 1'b0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_c_cmd", {28'd0, c_cmd}, 32'd0);
    chk("rst_c_address", c_address, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_f2d_valid", {31'd0, f2d_valid}, 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog row=%0d got=timeout want=finish", row);
    $fatal(1);
  end

  initial begin
    int          cnt;
    int          pops;
    logic [31:0] exp_pc;

    // Sequential fetch, latency 1, decode always ready
    add(1,0,0,1,EN,0,0,0, EX,32'h2000,1, 0,TI,0,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h2004,1, 1,TI,32'h2000,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h2008,1, 1,TI,32'h2004,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h200C,1, 1,TI,32'h2008,0);
    // Backpressure fills the FIFO after exactly four EXECUTEs
    add(1,0,0,0,EN,0,0,0, EX,32'h2000,1, 0,TI,0,0);
    add(0,1,0,0,EN,0,0,0, EX,32'h2004,1, 1,TI,32'h2000,0);
    add(0,1,0,0,EN,0,0,0, EX,32'h2008,1, 1,TI,32'h2000,0);
    add(0,1,0,0,EN,0,0,0, EX,32'h200C,1, 1,TI,32'h2000,0);
    add(0,1,0,0,EN,0,0,0, NO,0,0,         1,TI,32'h2000,0);
    add(0,0,0,0,EN,0,0,0, NO,0,0,         1,TI,32'h2000,0);
    add(0,0,0,1,EN,0,0,0, NO,0,0,         1,TI,32'h2004,0);
    add(0,0,0,1,EN,0,0,0, EX,32'h2010,1, 1,TI,32'h2008,0);
    // Reset mid-request (c_done ignored in IDLE), then START_BRANCH with fetch in flight
    add(1,1,0,1,EN,0,0,0, EX,32'h2000,1, 0,TI,0,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h2004,1, 1,TI,32'h2000,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h2008,1, 1,TI,32'h2004,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h200C,1, 1,TI,32'h2008,0);
    add(0,0,0,1,BR,32'h8000,0,0, EX,32'h200C,1, 0,TI,0,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h8000,1, 0,TI,0,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h8004,1, 1,TI,32'h8000,0);
    // FLUSH with fetch in flight
    add(1,0,0,1,EN,0,0,0, EX,32'h2000,1, 0,TI,0,0);
    add(0,0,0,1,FL,32'h4000,0,0, EX,32'h2000,1, 0,TI,0,0);
    add(0,1,0,1,EN,0,0,0, FA,0,1,         0,TI,0,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h4000,1, 0,TI,0,0);
    add(0,1,0,1,EN,0,0,0, EX,32'h4004,1, 1,TI,32'h4000,0);
    // Interrupt marker does not pop; two entries drain afterwards
    add(1,0,0,0,EN,0,0,0, EX,32'h2000,1, 0,TI,0,0);
    add(0,1,0,0,EN,0,0,0, EX,32'h2004,1, 1,TI,32'h2000,0);
    add(0,1,0,0,EN,0,0,0, EX,32'h2008,1, 1,TI,32'h2000,0);
    add(0,0,0,1,EN,0,1,0, EX,32'h2008,1, 1,TP,32'h2000,0);
    add(0,0,0,1,EN,0,1,0, EX,32'h2008,1, 1,TP,32'h2000,0);
    add(0,0,0,0,EN,0,0,0, EX,32'h2008,1, 1,TI,32'h2000,0);
    add(0,0,0,1,EN,0,0,0, EX,32'h2008,1, 1,TI,32'h2004,0);
    add(0,0,0,1,EN,0,0,0, EX,32'h2008,1, 0,TI,0,0);
    // dbg_mode: in-flight request completes with error response, then issue stops
    add(1,0,0,0,EN,0,0,0, EX,32'h2000,1, 0,TI,0,0);
    add(0,0,0,0,EN,0,0,1, EX,32'h2000,1, 0,TI,0,0);
    add(0,1,3,0,EN,0,0,1, NO,0,0,         1,TI,32'h2000,3);
    add(0,0,0,0,EN,0,0,1, NO,0,0,         1,TI,32'h2000,3);
    add(0,0,0,0,EN,0,0,0, EX,32'h2004,1, 1,TI,32'h2000,3);
    // ABORT blocks the first issue only
    add(1,1,0,0,AB,0,0,0, NO,0,0,         0,TI,0,0);
    add(0,0,0,0,EN,0,0,0, EX,32'h2000,1, 0,TI,0,0);
    // Address wrap past 0xFFFF_FFFC
    add(1,0,0,0,BR,32'hFFFF_FFFC,0,0, EX,32'hFFFF_FFFC,1, 0,TI,0,0);
    add(0,1,0,0,EN,0,0,0, EX,32'h0000_0000,1, 1,TI,32'hFFFF_FFFC,0);
    add(0,1,0,0,EN,0,0,0, EX,32'h0000_0004,1, 1,TI,32'hFFFF_FFFC,0);

    for (int i = 0; i < vecs.size(); i++) begin
      row = i;
      @(negedge clk);
      if (vecs[i].rst) do_reset();
      c_done           = vecs[i].done;
      c_response       = vecs[i].resp;
      c_load_data      = 32'hA000_0000 ^ c_address;
      f2d_ready        = vecs[i].ready;
      e2f_ready        = (vecs[i].e2f != EN);
      e2f_cmd          = vecs[i].e2f;
      e2f_branchtarget = vecs[i].tgt;
      interrupt_pending = vecs[i].irq;
      dbg_mode         = vecs[i].dbg;
      @(posedge clk);
      #1;
      chk("c_cmd", {28'd0, c_cmd}, {28'd0, vecs[i].ecmd});
      if (vecs[i].ecmd == EX) chk("c_address", c_address, vecs[i].eaddr);
      chk("busy", {31'd0, busy}, {31'd0, vecs[i].ebusy});
      chk("f2d_valid", {31'd0, f2d_valid}, {31'd0, vecs[i].evalid});
      if (vecs[i].evalid) begin
        chk("f2d_type", {30'd0, f2d_type}, {30'd0, vecs[i].etype});
        chk("f2d_pc", f2d_pc, vecs[i].epc);
        if (vecs[i].etype == TI) begin
          chk("f2d_instr", f2d_instr, 32'hA000_0000 ^ vecs[i].epc);
          chk("f2d_resp", {28'd0, f2d_resp}, {28'd0, vecs[i].eresp});
        end
      end
    end

    // Latency-3 cache, decode always ready: words arrive in address order
    row = 1000;
    @(negedge clk);
    do_reset();
    f2d_ready = 1'b1;
    cnt = 0;
    pops = 0;
    exp_pc = 32'h2000;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (f2d_valid) begin
        chk("lat3_pc", f2d_pc, exp_pc);
        chk("lat3_instr", f2d_instr, 32'hA000_0000 ^ exp_pc);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      c_done = 1'b0;
      if (c_cmd == EX) begin
        cnt++;
        if (cnt == 3) begin
          c_done = 1'b1;
          c_load_data = 32'hA000_0000 ^ c_address;
          cnt = 0;
        end
      end
    end
    chk("lat3_pop_count_ge10", {31'd0, (pops >= 10)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
